stream_xbar_arbiter: RTL
========================

Name: stream_xbar_arbiter

Overview:
- Control-side partner of the stream crossbar data mux. Decodes each source's destination and arbitrates per master port (round-robin, packet-granular). Produces the one-hot grant matrix that drives the data mux.
- Returns each master's ready to the granted source and forwards valid/last/id to the master.
- Data bytes never pass through this block; only handshake and routing control.

Parameters:
- S_DATA_COUNT, 5, number of source (slave-side) streams.
- M_DATA_COUNT, 3, number of master-side streams.
- T_ID___WIDTH, $clog2(S_DATA_COUNT), width of source index reported on m_id_o.
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), width of each source destination field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- s_valid_i  in  S_DATA_COUNT  per-source valid.
- s_last_i  in  S_DATA_COUNT  per-source end-of-packet.
- s_dest_i  in  T_DEST_WIDTH*S_DATA_COUNT  per-source destination; field j at [j*T_DEST_WIDTH +: T_DEST_WIDTH].
- s_ready_o  out  S_DATA_COUNT  per-source ready.
- m_valid_o  out  M_DATA_COUNT  per-master valid.
- m_last_o  out  M_DATA_COUNT  per-master end-of-packet.
- m_id_o  out  T_ID___WIDTH*M_DATA_COUNT  index of the source granted to master i.
- m_ready_i  in  M_DATA_COUNT  per-master ready.
- grant_o  out  S_DATA_COUNT*M_DATA_COUNT  bit i*S_DATA_COUNT+j = master i owns source j. Feeds the data mux grant input.

Behaviour:
- Reset state: grant_o=0, s_ready_o=0, m_valid_o=0, m_last_o=0, m_id_o=0. All masters IDLE. All round-robin pointers = S_DATA_COUNT-1, so source 0 has first priority.
- Per master i, an independent FSM with two states, IDLE and BUSY. Registered state: owner index and pointer.
- Request definition: req[i][j] = s_valid_i[j] & (s_dest_j == i) & source j not owned by any master.
  - Destinations >= M_DATA_COUNT match no master. That source stalls forever with s_ready=0 and is never dropped.
- IDLE:
  - If any req[i][*] is set, pick the first requester scanning j = ptr+1, ptr+2, … with wrap modulo S_DATA_COUNT.
  - On the next edge: owner<=j, state<=BUSY.
  - Grant latency is 1 cycle from the first valid to grant_o asserted.
  - With no request, stay IDLE.
- BUSY (owner j), combinational outputs:
  - grant_o row i = one-hot bit j.
  - m_valid_o[i] = s_valid_i[j].
  - m_last_o[i] = s_last_i[j].
  - m_id_o[i] = j.
  - s_ready_o[j] = m_ready_i[i].
- Transfer occurs when s_valid_i[j] & m_ready_i[i].
  - A transfer with s_last_i[j]=1 releases the grant: on the next edge state<=IDLE, ptr<=j, grant row cleared.
  - Releasing and regranting cannot happen in the same cycle. There is a minimum one idle cycle between packets on a master port.
- Outputs of unowned sources or IDLE masters are 0: s_ready_o, m_valid_o, m_last_o, grant row. m_id_o holds its last value.
- s_valid dropping mid-packet does not release the grant; only a last handshake does.
- Destination is sampled only at grant. Changes to s_dest during a packet are ignored until release.
- Single-beat packet (valid & last in the first granted cycle, ready high) completes in one beat. Grant is held exactly one cycle.
- Several masters may be BUSY concurrently with different sources.
- grant_o never has more than one bit set per row or per column.
- Reset asserted mid-packet returns every output to its reset value on the next edge. The partial packet is abandoned.

Test Plan:
- Reset: hold rst 3 cycles with all s_valid_i=1 → grant_o=0, s_ready_o=0, m_valid_o=0 throughout. Release → grants appear 1 cycle later.
- Single packet: source 2, dest 1, 4 beats, m_ready_i[1]=1 → grant_o bit 1*5+2 set from cycle+1. s_ready_o[2]=1 for 4 beats, m_id_o[1]=2, m_last_o[1] on beat 4. Grant cleared the cycle after.
- Contention: sources 0, 3, 4 all dest 0, 2-beat packets, continuous → service order 0,3,4,0,… Each packet is followed by one idle cycle. Unserved sources see s_ready_o=0.
- Backpressure: m_ready_i[2] toggles 1,0,0,1 during a packet from source 1 to dest 2 → s_ready_o[1] mirrors it. Beat count intact. Grant held across the stall and across an s_valid gap.
- Parallel and invalid dest: source 0→dest 0, source 1→dest 2, source 4→dest 3 simultaneously → grant_o bits 0 and 2*5+1 set. Source 4 stalls with s_ready_o[4]=0 and no grant bit.
- Reset mid-packet on beat 2 of 5 → all outputs 0 next edge. After release, same source re-arbitrates from pointer = S_DATA_COUNT-1.

Source files
------------

// File: rtl/stream_xbar_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : stream_xbar_arbiter
// Brief   : Per-master round-robin, packet-granular arbiter that drives the
//           stream crossbar data-mux grant matrix and handshake routing.
// Rev     : 1.0  initial release
// ============================================================================
module stream_xbar_arbiter #(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [T_ID___WIDTH-1:0] c_ptr_rst = T_ID___WIDTH'(S_DATA_COUNT - 1);

  state_t                  r_state     [M_DATA_COUNT];
  state_t                  w_state_nxt [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] r_owner     [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] w_owner_nxt [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] r_ptr       [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] w_ptr_nxt   [M_DATA_COUNT];
  logic [T_DEST_WIDTH-1:0] w_dest      [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] w_owned;

  for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_dest
    assign w_dest[j] = s_dest_i[j*T_DEST_WIDTH +: T_DEST_WIDTH];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      if (rst) begin
        r_state[i] <= ST_IDLE;
        r_owner[i] <= '0;
        r_ptr[i]   <= c_ptr_rst;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_owner[i] <= w_owner_nxt[i];
        r_ptr[i]   <= w_ptr_nxt[i];
      end
    end
  end

  always_comb begin
    logic [S_DATA_COUNT-1:0] w_row;
    logic [T_ID___WIDTH-1:0] w_sel;
    logic                    w_found;
    int                      w_idx;

    w_owned   = '0;
    grant_o   = '0;
    s_ready_o = '0;
    m_valid_o = '0;
    m_last_o  = '0;
    m_id_o    = '0;
    w_row     = '0;
    w_sel     = '0;
    w_found   = 1'b0;
    w_idx     = 0;

    // Ownership comes from registered state, so a source freed this cycle
    // cannot be claimed by anyone until the following edge.
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      if (r_state[i] == ST_BUSY) w_owned[r_owner[i]] = 1'b1;
    end

    for (int i = 0; i < M_DATA_COUNT; i++) begin
      w_state_nxt[i] = r_state[i];
      w_owner_nxt[i] = r_owner[i];
      w_ptr_nxt[i]   = r_ptr[i];
      m_id_o[i*T_ID___WIDTH +: T_ID___WIDTH] = r_owner[i];

      if (r_state[i] == ST_BUSY) begin
        w_row              = '0;
        w_row[r_owner[i]]  = 1'b1;
        grant_o[i*S_DATA_COUNT +: S_DATA_COUNT] = w_row;
        m_valid_o[i]          = s_valid_i[r_owner[i]];
        m_last_o[i]           = s_last_i[r_owner[i]];
        s_ready_o[r_owner[i]] = m_ready_i[i];
        if (s_valid_i[r_owner[i]] && m_ready_i[i] && s_last_i[r_owner[i]]) begin
          w_state_nxt[i] = ST_IDLE;
          w_ptr_nxt[i]   = r_owner[i];
        end
      end else begin
        // Scan ptr+1, ptr+2, ... so the last served source has lowest priority.
        w_found = 1'b0;
        for (int k = 1; k <= S_DATA_COUNT; k++) begin
          w_idx = int'(r_ptr[i]) + k;
          if (w_idx >= S_DATA_COUNT) w_idx = w_idx - S_DATA_COUNT;
          w_sel = T_ID___WIDTH'(w_idx);
          if (!w_found && s_valid_i[w_sel] && !w_owned[w_sel] &&
              (w_dest[w_sel] == T_DEST_WIDTH'(i))) begin
            w_found        = 1'b1;
            w_owner_nxt[i] = w_sel;
            w_state_nxt[i] = ST_BUSY;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
